// File: rtl/pipeline_pkg.sv
// Shared types and constants for the in-order pipeline hazard controller:
// freeze FSM encoding, forwarding select codes, shadow stage record.
package pipeline_pkg;
    localparam int REG_W = 5;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_FROZEN = 2'd2
    } frz_state_e;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b10,
        FWD_MEMWB = 2'b01
    } fwd_sel_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             reg_write;
        logic             is_load;
    } stage_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/hazard_match.sv
// One producer-stage vs one consumer-source compare; x0 is never a dependency.
module hazard_match
    import pipeline_pkg::*;
(
    input  logic             valid,
    input  logic             reg_write,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    output logic             match
);
    assign match = valid && reg_write && (rd != '0) && use_src && (src == rd);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit for a 5-stage pipeline: load-use stall, redirect flush, EX operand
// forwarding selects, and a debug freeze that drains the pipe before acking.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1_addr,
    input  logic [REG_W-1:0] id_rs2_addr,
    input  logic [REG_W-1:0] id_rd_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             freeze_req,
    output logic             freeze_ack,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    stage_t           ex_q, mem_q, wb_q, ex_d;
    frz_state_e       state_q;
    logic             freeze_ack_q;
    fwd_sel_e         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic             ex_m1, ex_m2, mem_m1, mem_m2;
    logic             use1, use2, redirect, load_use, hold;

    assign use1 = id_valid && id_uses_rs1;
    assign use2 = id_valid && id_uses_rs2;

    hazard_match u_ex_rs1  (.valid(ex_q.valid),  .reg_write(ex_q.reg_write),  .rd(ex_q.rd),
                            .src(id_rs1_addr), .use_src(use1), .match(ex_m1));
    hazard_match u_ex_rs2  (.valid(ex_q.valid),  .reg_write(ex_q.reg_write),  .rd(ex_q.rd),
                            .src(id_rs2_addr), .use_src(use2), .match(ex_m2));
    hazard_match u_mem_rs1 (.valid(mem_q.valid), .reg_write(mem_q.reg_write), .rd(mem_q.rd),
                            .src(id_rs1_addr), .use_src(use1), .match(mem_m1));
    hazard_match u_mem_rs2 (.valid(mem_q.valid), .reg_write(mem_q.reg_write), .rd(mem_q.rd),
                            .src(id_rs2_addr), .use_src(use2), .match(mem_m2));

    assign redirect = ex_redirect && ex_q.valid;
    assign load_use = ex_q.is_load && (ex_m1 || ex_m2);
    assign hold     = (state_q != ST_RUN);

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (!rst) begin
            if (hold) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
                if_id_flush  = redirect;
            end else if (redirect) begin
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall     = 1'b1;
                if_id_stall  = 1'b1;
                id_ex_bubble = 1'b1;
            end
        end
    end

    // Selects are captured with the instruction so EX sees them alongside its operands.
    always_comb begin
        ex_d = '{valid: id_valid, rd: id_rd_addr, reg_write: id_reg_write, is_load: id_is_load};
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (id_ex_bubble) begin
            ex_d = '0;
        end else begin
            if (ex_m1 && !ex_q.is_load) fwd_a_d = FWD_EXMEM;
            else if (mem_m1)            fwd_a_d = FWD_MEMWB;
            if (ex_m2 && !ex_q.is_load) fwd_b_d = FWD_EXMEM;
            else if (mem_m2)            fwd_b_d = FWD_MEMWB;
        end
        stall_cnt_d = (!hold && !redirect && load_use) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        flush_cnt_d = (!hold && redirect) ? sat_inc(flush_cnt_q) : flush_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            fwd_a_q      <= FWD_RF;
            fwd_b_q      <= FWD_RF;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            state_q      <= ST_RUN;
            freeze_ack_q <= 1'b0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= ex_q;
            wb_q        <= mem_q;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            case (state_q)
                ST_RUN: if (freeze_req) state_q <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!freeze_req) begin
                        state_q <= ST_RUN;
                    end else if (!ex_q.valid && !mem_q.valid && !wb_q.valid) begin
                        state_q      <= ST_FROZEN;
                        freeze_ack_q <= 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (!freeze_req) begin
                        state_q      <= ST_RUN;
                        freeze_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_RUN;
                    freeze_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign freeze_ack = freeze_ack_q;
    assign fwd_a      = fwd_a_q;
    assign fwd_b      = fwd_b_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;
    import pipeline_pkg::*;

    logic        clk = 1'b0;
    logic        rst, id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_is_load;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic        ex_redirect, freeze_req, freeze_ack;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_bubble;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    int          checks = 0;
    int          errors = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_reg_write(id_reg_write),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .freeze_req(freeze_req),
        .freeze_ack(freeze_ack), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic u1, input logic u2, input logic [6:0] op);
        id_valid     = v;
        id_rs1_addr  = rs1;
        id_rs2_addr  = rs2;
        id_rd_addr   = rd;
        id_uses_rs1  = u1;
        id_uses_rs2  = u2;
        id_is_load   = (op == OP_LOAD);
        id_reg_write = (op == OP_LOAD) || (op == OP_OP) || (op == OP_OPIMM);
    endtask

    task automatic idle(input int n);
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, OP_BRANCH);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; ex_redirect = 1'b0; freeze_req = 1'b0;
        set_id(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, OP_LOAD);
        tick(); tick();
        checks++; if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble} !== 4'b0) begin errors++; $display("FAIL rst_ctrl got %b exp 0000", {pc_stall, if_id_stall, if_id_flush, id_ex_bubble}); end
        checks++; if ({fwd_a, fwd_b, freeze_ack} !== 5'b0) begin errors++; $display("FAIL rst_fwd_ack got %b exp 00000", {fwd_a, fwd_b, freeze_ack}); end
        checks++; if ({stall_cnt, flush_cnt} !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h exp 0", {stall_cnt, flush_cnt}); end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_load_use();
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, OP_LOAD);
        #1;
        checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL lu_first_nostall got %b exp 0", pc_stall); end
        tick();
        set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, OP_OP);
        #1;
        checks++; if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b1110) begin errors++; $display("FAIL lu_stall got %b exp 1110", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush}); end
        tick();
        checks++; if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b000) begin errors++; $display("FAIL lu_release got %b exp 000", {pc_stall, if_id_stall, id_ex_bubble}); end
        tick();
        idle(0);
        checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL lu_fwd_a got %b exp 01", fwd_a); end
        checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b got %b exp 00", fwd_b); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
        idle(3);
    endtask

    task automatic test_forward();
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1, OP_OP);
        tick();
        set_id(1'b1, 5'd5, 5'd5, 5'd8, 1'b1, 1'b1, OP_OP);
        #1;
        checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fw_nostall got %b exp 0", pc_stall); end
        tick();
        checks++; if ({fwd_a, fwd_b} !== 4'b1010) begin errors++; $display("FAIL fw_exmem got %b exp 1010", {fwd_a, fwd_b}); end
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, OP_OP);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd8, 1'b1, 1'b1, OP_OP);
        tick();
        checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL fw_x0 got %b exp 0000", {fwd_a, fwd_b}); end
        set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1, OP_OPIMM);
        tick();
        idle(1);
        set_id(1'b1, 5'd9, 5'd9, 5'd10, 1'b1, 1'b0, OP_OP);
        tick();
        checks++; if ({fwd_a, fwd_b} !== 4'b0100) begin errors++; $display("FAIL fw_memwb got %b exp 0100", {fwd_a, fwd_b}); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL fw_stall_cnt got %0d exp 1", stall_cnt); end
        idle(3);
    endtask

    task automatic test_redirect();
        set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, OP_LOAD);
        tick();
        set_id(1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, OP_OP);
        ex_redirect = 1'b1;
        #1;
        checks++; if ({if_id_flush, id_ex_bubble, pc_stall, if_id_stall} !== 4'b1100) begin errors++; $display("FAIL rd_ctrl got %b exp 1100", {if_id_flush, id_ex_bubble, pc_stall, if_id_stall}); end
        tick();
        ex_redirect = 1'b0;
        idle(0);
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL rd_flush_cnt got %0d exp 1", flush_cnt); end
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL rd_stall_cnt got %0d exp 1", stall_cnt); end
        idle(3);
    endtask

    task automatic test_freeze();
        set_id(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b1, OP_OP); tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b1, OP_OP); tick();
        set_id(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b1, OP_OP); tick();
        idle(0);
        freeze_req = 1'b1;
        #1;
        checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fz_run got %b exp 0", pc_stall); end
        tick();
        checks++; if ({pc_stall, if_id_stall, id_ex_bubble, freeze_ack} !== 4'b1110) begin errors++; $display("FAIL fz_drain got %b exp 1110", {pc_stall, if_id_stall, id_ex_bubble, freeze_ack}); end
        tick(); tick();
        checks++; if (freeze_ack !== 1'b0) begin errors++; $display("FAIL fz_ack_early got %b exp 0", freeze_ack); end
        tick();
        checks++; if ({freeze_ack, pc_stall, if_id_stall, id_ex_bubble} !== 4'b1111) begin errors++; $display("FAIL fz_frozen got %b exp 1111", {freeze_ack, pc_stall, if_id_stall, id_ex_bubble}); end
        freeze_req = 1'b0;
        tick();
        checks++; if ({freeze_ack, pc_stall} !== 2'b00) begin errors++; $display("FAIL fz_release got %b exp 00", {freeze_ack, pc_stall}); end
        checks++; if ({stall_cnt, flush_cnt} !== {16'd1, 16'd1}) begin errors++; $display("FAIL fz_cnt got %h exp 00010001", {stall_cnt, flush_cnt}); end
    endtask

    task automatic test_reset_drain();
        set_id(1'b1, 5'd1, 5'd2, 5'd13, 1'b1, 1'b1, OP_OP);
        tick();
        idle(0);
        freeze_req = 1'b1;
        tick();
        checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rd_in_drain got %b exp 1", pc_stall); end
        rst = 1'b1;
        #1;
        checks++; if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble} !== 4'b0) begin errors++; $display("FAIL rdr_during got %b exp 0000", {pc_stall, if_id_stall, if_id_flush, id_ex_bubble}); end
        tick();
        rst = 1'b0;
        freeze_req = 1'b0;
        #1;
        checks++; if ({pc_stall, if_id_stall, if_id_flush, id_ex_bubble, freeze_ack} !== 5'b0) begin errors++; $display("FAIL rdr_after got %b exp 00000", {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, freeze_ack}); end
        checks++; if ({stall_cnt, flush_cnt, fwd_a, fwd_b} !== 36'h0) begin errors++; $display("FAIL rdr_cnt got %h exp 0", {stall_cnt, flush_cnt, fwd_a, fwd_b}); end
    endtask

    task automatic test_saturate();
        // lw x5,0(x5) held in ID stalls on every other cycle against itself
        set_id(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, OP_LOAD);
        repeat (20) tick();
        checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL sat_early got %0d exp 10", stall_cnt); end
        repeat (131068 - 20) tick();
        checks++; if (stall_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_fffe got %h exp fffe", stall_cnt); end
        repeat (2) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_ffff got %h exp ffff", stall_cnt); end
        repeat (10) tick();
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", stall_cnt); end
        checks++; if (flush_cnt !== 16'h0) begin errors++; $display("FAIL sat_flush got %h exp 0", flush_cnt); end
        idle(1);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_redirect();
        test_freeze();
        test_reset_drain();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have no parameters; register index width 5, counter width 16 (fixed).
REQ-002 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-003 SHALL have ports: id_valid in 1, ID holds a real instruction; id_rs1_addr / id_rs2_addr / id_rd_addr in 5, decoded register fields.
REQ-004 SHALL have ports: id_uses_rs1 / id_uses_rs2 in 1, source operand read; id_reg_write in 1; id_is_load in 1 (MemtoReg selects memory).
REQ-005 SHALL have ports: ex_redirect in 1, taken branch or jump resolved in EX this cycle.
REQ-006 SHALL have ports: freeze_req in 1, debug drain request; freeze_ack out 1, pipeline empty and held.
REQ-007 SHALL have ports: pc_stall out 1, hold PC; if_id_stall out 1, hold IF/ID; if_id_flush out 1, zero IF/ID; id_ex_bubble out 1, load NOP into ID/EX.
REQ-008 SHALL have ports: fwd_a / fwd_b out 2, EX operand source (00 regfile, 10 EX/MEM, 01 MEM/WB); stall_cnt / flush_cnt out 16.

Function
REQ-009 SHALL keep shadow stage regs EX, MEM, WB, each {valid, rd, reg_write, is_load}; every cycle MEM<=EX and WB<=MEM.
REQ-010 SHALL load EX from ID fields (valid=id_valid) when id_ex_bubble=0, else load EX with valid=0.
REQ-011 SHALL define hazard match only if stage valid, reg_write=1, rd!=0, and the used source equals rd; x0 never matches.
REQ-012 SHALL flag load_use when ID valid and EX stage is_load and matches id_rs1 (if used) or id_rs2 (if used).
REQ-013 SHALL on ex_redirect (EX valid): if_id_flush=1, id_ex_bubble=1, pc_stall=0, if_id_stall=0, same cycle (combinational).
REQ-014 SHALL on load_use without redirect: pc_stall=1, if_id_stall=1, id_ex_bubble=1 for exactly one cycle, then proceed.
REQ-015 SHALL give ex_redirect priority over load_use; both asserted counts as flush only.
REQ-016 SHALL register fwd_a/fwd_b at the edge where ID enters EX: 10 if match vs current EX stage (non-load), else 01 if match vs MEM stage, else 00; bubble cycles register 00.
REQ-017 SHALL not forward from WB; regfile is write-first, same-cycle WB->ID read needs no action.
REQ-018 SHALL implement FSM RUN, DRAIN, FROZEN.
REQ-019 SHALL in RUN go to DRAIN when freeze_req=1.
REQ-020 SHALL in DRAIN assert pc_stall=1, if_id_stall=1, id_ex_bubble=1; go FROZEN when EX, MEM, WB all invalid; a redirect during DRAIN still flushes IF/ID.
REQ-021 SHALL in FROZEN hold the DRAIN outputs and assert freeze_ack=1 (registered, from FSM state).
REQ-022 SHALL in FROZEN return to RUN when freeze_req=0; freeze_req dropped during DRAIN returns to RUN next cycle.
REQ-023 SHALL increment stall_cnt each load_use stall cycle and flush_cnt each redirect cycle, saturating at 0xFFFF; freeze cycles count in neither.

Reset
REQ-024 SHALL on rst=1 at clk edge clear shadow stages (valid=0), fwd_a=fwd_b=00, counters=0, FSM=RUN, freeze_ack=0.
REQ-025 SHALL drive pc_stall, if_id_stall, if_id_flush, id_ex_bubble to 0 while rst=1.
REQ-026 SHALL make reset mid-stall, mid-drain or mid-freeze take effect in one cycle with no residual stall.

Structure
REQ-027 SHALL place FSM state encoding, fwd select codes (FWD_RF=00, FWD_EXMEM=10, FWD_MEMWB=01) and opcode constants in shared package pipeline_pkg.
REQ-028 SHALL use one sub-module hazard_match (valid, reg_write, rd, src, use -> match), instantiated per stage/source pair.

Verification
REQ-029 SHALL test: lw x5 then add x6,x5,x7 -> one cycle pc_stall=if_id_stall=id_ex_bubble=1, then add in EX with fwd_a=01, stall_cnt=1.
REQ-030 SHALL test: add x5 then sub x8,x5,x5 -> no stall, fwd_a=fwd_b=10; with x0 as rd -> fwd=00.
REQ-031 SHALL test: ex_redirect=1 with load_use same cycle -> if_id_flush=1, id_ex_bubble=1, pc_stall=0, flush_cnt=1, stall_cnt unchanged.
REQ-032 SHALL test: freeze_req=1 with 3 valid instrs in flight -> freeze_ack=1 after EX/MEM/WB empty (4 cycles), drop req -> RUN, ack=0 next cycle.
REQ-033 SHALL test: rst=1 during DRAIN -> next cycle all outputs 0, FSM RUN, counters 0.
REQ-034 SHALL test: 65 540 consecutive load-use pairs -> stall_cnt saturates at 0xFFFF.
